tdm_demux_4ch: RTL and testbench

TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_slot_deser.sv | 50 +++++
 rtl/tdm_demux_4ch.sv | 134 +++++++++++++
 tb/tb_tdm_demux_4ch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-channel TDM demultiplexer
//
// Purpose : frame-lock state encoding and frame geometry shared by the
//           demultiplexer top level and its testbench.
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_deser.sv
// rtl/tdm_slot_deser.sv - MSB-first serial-to-parallel slot word deserializer
//
// Purpose : assembles one WORD_W-bit slot word from qualified serial beats.
// Ports   :
//   clk, rst      clock and asynchronous active-high reset
//   din           serial data bit
//   i_shift       shift din in as the next bit of the current word
//   i_load_first  start a new word with din as its MSB (wins over i_shift)
//   o_word        completed word, valid while o_done is high
//   o_done        this beat supplies the last bit of the word
//   o_at_first    next beat will be the MSB of a word
module tdm_slot_deser #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              i_shift,
  input  logic              i_load_first,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done,
  output logic              o_at_first
);

  localparam int               CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  // Only WORD_W-1 bits are stored: the final bit is taken straight from din,
  // so the completed word is available combinationally on the done beat.
  logic [WORD_W-2:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  assign o_done     = i_shift && !i_load_first && (r_cnt == CNT_LAST);
  assign o_word     = {r_shift, din};
  assign o_at_first = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load_first) begin
      r_shift <= (WORD_W-1)'(din);
      r_cnt   <= CNT_W'(1);
    end else if (i_shift) begin
      r_shift <= (r_shift << 1) | (WORD_W-1)'(din);
      r_cnt   <= o_done ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - 4-slot serial TDM demultiplexer with frame lock
//
// Purpose : locks to fsync, deserializes four WORD_W-bit slots per frame and
//           publishes them together once slot 3 completes.
// Ports   :
//   clk, rst      clock and asynchronous active-high reset
//   din           serial data, MSB of each slot first
//   din_valid     qualifies din and fsync
//   fsync         first bit of slot 0
//   a, b, c, d    last complete words of slots 0..3
//   out_valid     one-cycle pulse when a..d take a new frame
//   sync_err      one-cycle pulse on a misplaced fsync
//   locked        frame lock acquired
module tdm_demux_4ch #(
  parameter int WORD_W = 8,
  parameter int SLOTS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              fsync,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] c,
  output logic [WORD_W-1:0] d,
  output logic              out_valid,
  output logic              sync_err,
  output logic              locked
);

  import tdm_pkg::*;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  tdm_state_t        r_state, w_next;
  logic [SLOT_W-1:0] r_slot;
  logic [WORD_W-1:0] r_stage0, r_stage1, r_stage2;
  logic [WORD_W-1:0] r_a, r_b, r_c, r_d;
  logic              r_out_valid, r_sync_err;

  logic              w_shift, w_load_first, w_resync;
  logic [WORD_W-1:0] w_word;
  logic              w_done, w_at_first;

  tdm_slot_deser #(.WORD_W(WORD_W)) u_deser (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .i_shift      (w_shift),
    .i_load_first (w_load_first),
    .o_word       (w_word),
    .o_done       (w_done),
    .o_at_first   (w_at_first)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_next;
  end

  // A frame-start fsync is just a normal shift; fsync anywhere else restarts
  // the frame on this very beat, which also pre-empts a slot-3 completion.
  always_comb begin
    w_next       = r_state;
    w_shift      = 1'b0;
    w_load_first = 1'b0;
    w_resync     = 1'b0;
    case (r_state)
      HUNT: begin
        if (din_valid && fsync) begin
          w_next       = LOCKED;
          w_load_first = 1'b1;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (fsync && !((r_slot == '0) && w_at_first)) begin
            w_resync     = 1'b1;
            w_load_first = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot      <= '0;
      r_stage0    <= '0;
      r_stage1    <= '0;
      r_stage2    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= w_resync;
      if (w_load_first) begin
        r_slot <= '0;
      end else if (w_done) begin
        r_slot <= r_slot + SLOT_W'(1);
        if (r_slot == SLOT_LAST) begin
          r_a         <= r_stage0;
          r_b         <= r_stage1;
          r_c         <= r_stage2;
          r_d         <= w_word;
          r_out_valid <= 1'b1;
        end else begin
          case (r_slot)
            2'd0:    r_stage0 <= w_word;
            2'd1:    r_stage1 <= w_word;
            default: r_stage2 <= w_word;
          endcase
        end
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign c         = r_c;
  assign d         = r_d;
  assign out_valid = r_out_valid;
  assign sync_err  = r_sync_err;
  assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb/tb_tdm_demux_4ch.sv - randomized self-checking bench for tdm_demux_4ch
module tb_tdm_demux_4ch;

  localparam int W = 8;
  localparam int FRAME_BITS = 4 * W;

  logic         clk = 1'b0;
  logic         rst, din, din_valid, fsync;
  logic [W-1:0] a, b, c, d;
  logic         out_valid, sync_err, locked;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.WORD_W(W), .SLOTS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .sync_err  (sync_err),
    .locked    (locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lock flag plus a single bit position within the frame.
  bit           m_locked;
  int           m_pos;
  logic [W-1:0] m_w   [4];
  logic [W-1:0] m_out [4];
  bit           m_ov, m_se;

  int cyc = 0;
  int ov_cnt = 0, se_cnt = 0, ov_last = 0, ov_prev = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_ov     = 1'b0;
    m_se     = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
  endtask

  task automatic model_put(input logic bv);
    m_w[m_pos / W][W - 1 - (m_pos % W)] = bv;
    m_pos++;
  endtask

  task automatic model_step(input logic v, input logic f, input logic bv);
    m_ov = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_locked = 1'b1;
          m_pos    = 0;
          model_put(bv);
        end
      end else begin
        if (f && m_pos != 0) begin
          m_se  = 1'b1;
          m_pos = 0;
        end
        model_put(bv);
        if (m_pos == FRAME_BITS) begin
          m_ov  = 1'b1;
          m_out = m_w;
          m_pos = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("locked",    32'(locked),    32'(m_locked));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("sync_err",  32'(sync_err),  32'(m_se));
    chk("a", 32'(a), 32'(m_out[0]));
    chk("b", 32'(b), 32'(m_out[1]));
    chk("c", 32'(c), 32'(m_out[2]));
    chk("d", 32'(d), 32'(m_out[3]));
  endtask

  task automatic beat(input logic v, input logic f, input logic bv);
    din_valid = v;
    fsync     = f;
    din       = bv;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step(v, f, bv);
    #1;
    check_outputs();
    if (out_valid) begin
      ov_cnt++;
      ov_prev = ov_last;
      ov_last = cyc;
    end
    if (sync_err) se_cnt++;
  endtask

  task automatic idle_beat();
    beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3,
                            input bit fs, input int gap_pct, input bit fixed_gaps,
                            input int bad_at);
    logic [W-1:0] wd [4];
    logic         bv;
    wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (fixed_gaps && (i == W + 2 || i == 3 * W + 3))
        repeat (3) idle_beat();
      while (int'($urandom_range(0, 99)) < gap_pct) idle_beat();
      bv = wd[i / W][W - 1 - (i % W)];
      beat(1'b1, (fs && i == 0) || (i == bad_at), bv);
    end
  endtask

  task automatic check_words(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [W-1:0] ec, input logic [W-1:0] ed);
    chk({tag, ".a"}, 32'(a), 32'(ea));
    chk({tag, ".b"}, 32'(b), 32'(eb));
    chk({tag, ".c"}, 32'(c), 32'(ec));
    chk({tag, ".d"}, 32'(d), 32'(ed));
  endtask

  int ov0, se0, end_cyc;

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; fsync = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) m_w[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Random bits before the first fsync must be ignored.
    repeat (10) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("hunt_locked", 32'(locked), 32'd0);
    ov0 = ov_cnt;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 0, 1'b0, -1);
    chk("first_frame_ov", 32'(ov_cnt - ov0), 32'd1);
    check_words("first_frame", 8'h11, 8'h22, 8'h33, 8'h44);

    // Contiguous frame: out_valid lands on the edge after the 32nd bit.
    ov0 = ov_cnt; se0 = se_cnt;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1, 0, 1'b0, -1);
    end_cyc = cyc;
    chk("contig_ov", 32'(ov_cnt - ov0), 32'd1);
    chk("contig_latency", 32'(ov_last), 32'(end_cyc));
    chk("contig_se", 32'(se_cnt - se0), 32'd0);
    check_words("contig", 8'hA5, 8'h3C, 8'h0F, 8'hF0);

    // Same frame with valid gaps inside slots 1 and 3.
    ov0 = ov_cnt;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 1'b1, 0, 1'b1, -1);
    chk("gap_ov", 32'(ov_cnt - ov0), 32'd1);
    check_words("gap", 8'hA5, 8'h3C, 8'h0F, 8'hF0);

    // Back-to-back frames, fsync only on the first (flywheel).
    ov0 = ov_cnt;
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 0, 1'b0, -1);
    send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0, 0, 1'b0, -1);
    chk("b2b_ov", 32'(ov_cnt - ov0), 32'd2);
    chk("b2b_spacing", 32'(ov_last - ov_prev), 32'(FRAME_BITS));
    check_words("b2b", 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    // Misplaced fsync at slot 2 bit 3 starts the next full frame.
    ov0 = ov_cnt; se0 = se_cnt;
    repeat (2 * W + 3) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    check_words("abort_hold", 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 0, 1'b0, -1);
    chk("resync_se", 32'(se_cnt - se0), 32'd1);
    chk("resync_ov", 32'(ov_cnt - ov0), 32'd1);
    check_words("resync", 8'h01, 8'h02, 8'h03, 8'h04);

    // Misplaced fsync on the would-be last bit of slot 3: resync wins.
    ov0 = ov_cnt; se0 = se_cnt;
    send_frame(8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b1, 0, 1'b0, FRAME_BITS - 1);
    chk("last_bit_se", 32'(se_cnt - se0), 32'd1);
    chk("last_bit_ov", 32'(ov_cnt - ov0), 32'd0);
    check_words("last_bit", 8'h01, 8'h02, 8'h03, 8'h04);

    // Asynchronous reset in the middle of slot 2.
    repeat (2 * W + 4) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (3) beat(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b0;
    ov0 = ov_cnt;
    repeat (5) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("post_reset_ov", 32'(ov_cnt - ov0), 32'd0);
    send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b1, 0, 1'b0, -1);
    chk("post_reset_frame_ov", 32'(ov_cnt - ov0), 32'd1);
    check_words("post_reset", 8'hAA, 8'hBB, 8'hCC, 8'hDD);

    // Randomized frames, gaps, dropped fsyncs and misplaced fsyncs.
    for (int n = 0; n < 40; n++) begin
      send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 25)), 1'b0,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FRAME_BITS - 1)) : -1);
    end
    repeat (4) idle_beat();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
